// File: rtl/pattern_count_engine_if.sv
// Byte-stream and result bundle of the pattern-count engine.
interface pattern_count_engine_if #(
  parameter int PAT_W = 5,
  parameter int CNT_W = 8
);
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             byte_ready;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] ctb;
  logic [CNT_W-1:0] cto;
  logic [CNT_W-1:0] cts;

  modport master (
    output start, pattern, byte_valid, byte_data,
    input  byte_ready, busy, done, ctb, cto, cts
  );

  modport slave (
    input  start, pattern, byte_valid, byte_data,
    output byte_ready, busy, done, ctb, cto, cts
  );
endinterface

// File: rtl/pattern_count_engine.sv
// Streaming search of an MSB-first byte string for a PAT_W-bit pattern,
// producing in-byte, byte-hit and whole-string match counts.
//
//   state | meaning
//   IDLE  | waiting for start after reset
//   RUN   | accepting message bytes, counts update per accepted byte
//   DONE  | final counts held, waiting for next start
module pattern_count_engine #(
  parameter int PAT_W   = 5,
  parameter int N_BYTES = 32,
  parameter int CNT_W   = 8
) (
  input logic              clk,
  input logic              reset,
  pattern_count_engine_if.slave bus
);

  localparam int TW = (PAT_W > 1) ? PAT_W - 1 : 1;
  localparam int SW = CNT_W + 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q;
  logic [TW-1:0]    tail_q;
  logic [7:0]       idx_q;
  logic [CNT_W-1:0] ctb_q, cto_q, cts_q;
  logic [3:0]       m_cnt, c_cnt;
  logic [15:0]      x;
  logic             byte_ready, busy, done;
  logic             start_ok, accept, last;

  assign start_ok = bus.start && (state_q == S_IDLE || state_q == S_DONE);
  assign accept   = bus.byte_valid && byte_ready;
  assign last     = (idx_q == 8'(N_BYTES - 1));

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [3:0] b);
    logic [SW-1:0] s;
    s = SW'(a) + SW'(b);
    return (s > SW'(CNT_MAX)) ? CNT_MAX : s[CNT_W-1:0];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (bus.start) state_d = S_RUN;
      S_RUN:          if (accept && last) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_RUN:   begin byte_ready = 1'b1; busy = 1'b1; end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Cross windows start inside the previous byte's low PAT_W-1 bits and
  // run into the current byte; together with the in-byte windows they
  // cover every bit position of the concatenated string exactly once.
  always_comb begin
    m_cnt = '0;
    c_cnt = '0;
    x     = {8'(tail_q), bus.byte_data};
    for (int k = 0; k <= 8 - PAT_W; k++)
      if (PAT_W'(bus.byte_data >> k) == pat_q) m_cnt = m_cnt + 4'd1;
    if (idx_q != '0)
      for (int j = 0; j < PAT_W - 1; j++)
        if (PAT_W'(x >> (7 - j)) == pat_q) c_cnt = c_cnt + 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q  <= '0;
      tail_q <= '0;
      idx_q  <= '0;
      ctb_q  <= '0;
      cto_q  <= '0;
      cts_q  <= '0;
    end else if (start_ok) begin
      pat_q  <= bus.pattern;
      tail_q <= '0;
      idx_q  <= '0;
      ctb_q  <= '0;
      cto_q  <= '0;
      cts_q  <= '0;
    end else if (accept) begin
      ctb_q  <= sat_add(ctb_q, m_cnt);
      cto_q  <= sat_add(cto_q, 4'(m_cnt != 4'd0));
      cts_q  <= sat_add(cts_q, m_cnt + c_cnt);
      tail_q <= bus.byte_data[TW-1:0];
      idx_q  <= idx_q + 8'd1;
    end
  end

  assign bus.byte_ready = byte_ready;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.ctb        = ctb_q;
  assign bus.cto        = cto_q;
  assign bus.cts        = cts_q;

endmodule
